bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary converter: 5-digit packed BCD in, 14-bit unsigned binary out.
//  Inverse of the team's combinational binary-to-BCD path.
//  Sits between the digit-entry front end and the 14-bit datapath.
//  Horner evaluation, one digit per clock, MS digit first: acc = acc*10 + digit.
//  Start/ready/valid handshake with overflow and invalid-digit flags.
// PARAMETERS
//  NDIG  5   number of BCD digits; bcd_in[3:0] is units, bcd_in[4*NDIG-1 -: 4] is MS digit
//  BW    14  binary output width; max representable value is 2^BW-1 (16383)
// PORTS
//  clk        in   1       single system clock; all state changes on rising edge
//  rst_n      in   1       reset, synchronous, active-low
//  start      in   1       request conversion; accepted only when ready=1
//  bcd_in     in   4*NDIG  packed BCD operand; sampled only on the accepting edge
//  ready      out  1       1 = IDLE, can accept start
//  valid      out  1       one-cycle pulse: bin_out/ovf/bad_digit updated this cycle
//  bin_out    out  BW      converted value; held until the next completion
//  ovf        out  1       value exceeded 2^BW-1; held with bin_out
//  bad_digit  out  1       some digit > 9; held with bin_out
// BEHAVIOUR
//  Clock/reset: one clock (clk); reset rst_n is synchronous and active-low.
//  Reset values: state=IDLE, ready=1, valid=0, bin_out=0, ovf=0, bad_digit=0, acc=0, idx=0.
//  FSM states: IDLE, CONV.
//   IDLE: ready=1. On an edge with start=1:
//    - latch bcd_in into a shift register
//    - clear acc and the sticky ovf/bad flags
//    - idx=NDIG-1; go to CONV
//   CONV: ready=0. Each edge consumes the digit d at idx (MS first):
//    - bad_s |= (d>9)
//    - nxt = acc*10 + d, computed in BW+4 bits
//    - if nxt > 2^BW-1 or ovf_s: ovf_s=1 and acc is clamped to 2^BW-1 (never wraps)
//    - otherwise acc=nxt
//    - decrement idx
//   Last digit (idx=0) edge:
//    - register outputs, pulse valid=1, return to IDLE
//    - bin_out = 0 if bad_s, else 2^BW-1 if ovf_s, else acc
//    - ovf=ovf_s and bad_digit=bad_s, both reported independently
//  Latency: start accepted at edge E; digits processed at edges E+1..E+NDIG.
//   valid=1 and ready=1 from edge E+NDIG; valid drops at edge E+NDIG+1.
//   Back-to-back: start may be high in the valid cycle and is accepted at E+NDIG+1.
//   Throughput: one result per NDIG+1 cycles.
//  start while ready=0: ignored, not queued. bcd_in changes during CONV: no effect.
//  start held high continuously: a new conversion starts on every IDLE edge.
//  Reset mid-CONV (rst_n=0 at any edge):
//   - immediate return to reset values; no valid pulse
//   - the partial result is discarded
//  Arithmetic: acc*10 = (acc<<3)+(acc<<1). All math is unsigned; no signed types.
//  bin_out, ovf and bad_digit are only ever written together, on the valid edge.
// TESTING
//  1 bcd_in=20'h12345, start 1 cycle -> valid exactly 5 edges later, bin_out=14'h3039, ovf=0, bad=0
//  2 20'h16383 -> bin_out=14'h3FFF, ovf=0; 20'h16384 -> bin_out=14'h3FFF, ovf=1;
//    20'h99999 -> 14'h3FFF, ovf=1; 20'h00000 -> 0
//  3 20'h0A123 -> bin_out=0, bad_digit=1; 20'h9F999 -> bin_out=0, bad_digit=1, ovf=1
//  4 start 20'h00042, then pulse start with 20'h00007 two cycles later
//    -> one valid only, bin_out=14'd42, ready low for 5 cycles
//  5 rst_n=0 for one edge at the third CONV cycle -> no valid, all outputs 0, ready=1 next cycle;
//    next start 20'h00100 -> 14'd100
//  6 Exhaustive sweep of 0..16383 as BCD, plus random 5-digit BCD
//    -> bin_out matches the golden decimal value (or saturation)
//    -> also feed each bin_out back through the team's binary-to-BCD block and confirm it round-trips

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using Horner's rule, one digit per clock, MS digit first.
// Saturates at 2^BW-1 on overflow and forces a zero result when any digit is outside 0..9.
module bcd_to_bin_seq #(
  parameter int NDIG = 5,
  parameter int BW   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              ready,
  output logic              valid,
  output logic [BW-1:0]     bin_out,
  output logic              ovf,
  output logic              bad_digit
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [BW-1:0] MAXV = '1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state_reg;
  logic [4*NDIG-1:0] sr_reg;
  logic [BW-1:0]     acc_reg;
  logic [IW-1:0]     idx_reg;
  logic              ovf_s_reg;
  logic              bad_s_reg;

  logic [3:0]        digits [NDIG];
  logic [3:0]        d;
  logic [BW+3:0]     nxt;
  logic              bad_next;
  logic              ovf_next;
  logic [BW-1:0]     acc_next;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
      assign digits[gi] = sr_reg[4*gi +: 4];
    end
  endgenerate

  // Four guard bits keep acc*10 + 15 from wrapping before the saturation compare.
  always_comb begin
    d = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_reg == IW'(i)) d = digits[i];
    end
    nxt      = ({4'b0, acc_reg} << 3) + ({4'b0, acc_reg} << 1) + {{BW{1'b0}}, d};
    bad_next = bad_s_reg | (d > 4'd9);
    ovf_next = ovf_s_reg | (nxt > {4'b0, MAXV});
    acc_next = ovf_next ? MAXV : nxt[BW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      ovf_s_reg <= 1'b0;
      bad_s_reg <= 1'b0;
      ready     <= 1'b1;
      valid     <= 1'b0;
      bin_out   <= '0;
      ovf       <= 1'b0;
      bad_digit <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            sr_reg    <= bcd_in;
            acc_reg   <= '0;
            ovf_s_reg <= 1'b0;
            bad_s_reg <= 1'b0;
            idx_reg   <= IW'(NDIG - 1);
            ready     <= 1'b0;
            state_reg <= CONV;
          end
        end
        CONV: begin
          acc_reg   <= acc_next;
          ovf_s_reg <= ovf_next;
          bad_s_reg <= bad_next;
          if (idx_reg == '0) begin
            valid     <= 1'b1;
            ready     <= 1'b1;
            state_reg <= IDLE;
            bin_out   <= bad_next ? '0 : (ovf_next ? MAXV : acc_next);
            ovf       <= ovf_next;
            bad_digit <= bad_next;
          end else begin
            idx_reg <= idx_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
